// File: rtl/vga_sync_receiver_pkg.sv
// ---------------------------------------------------------------------------
// vga_sync_receiver_pkg
//
// Shared VGA timing constants and receiver state encoding. The generator and
// the receiver both import this package so they agree on standard 640x480
// timing.
//
// Contents:
//   CNT_W            counter width for horizontal/vertical positions
//   H_*_STD, V_*_STD standard 640x480@60 timing (total/visible/sync start)
//   rx_state_e       2-bit receiver lock state encoding
//   in_active()      true when a position lies inside the visible window
// ---------------------------------------------------------------------------
package vga_sync_receiver_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_TOTAL_STD      = 800;
    localparam int unsigned H_VIS_STD        = 640;
    localparam int unsigned H_SYNC_START_STD = 656;
    localparam int unsigned V_TOTAL_STD      = 525;
    localparam int unsigned V_VIS_STD        = 480;
    localparam int unsigned V_SYNC_START_STD = 490;

    typedef enum logic [1:0] {
        StSearch   = 2'd0,
        StLineChk  = 2'd1,
        StFrameChk = 2'd2,
        StLocked   = 2'd3
    } rx_state_e;

    function automatic logic in_active(
        input logic [CNT_W-1:0] h,
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] h_vis,
        input logic [CNT_W-1:0] v_vis
    );
        return (h < h_vis) && (v < v_vis);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//
// Falling-edge detector for an active-low sync line sampled on pixel ticks.
// An edge is a sampled 1 on the previous tick followed by a sampled 0 on the
// current tick. The first tick after reset only primes the history, so a line
// that is already low when reset releases never reports an edge.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   tick       pixel strobe; the sync line is sampled only when it is high
//   sync_line  sync input (active-low)
//   fall       combinational pulse, high on the tick where the edge is seen
// ---------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sync_line,
    output logic fall
);

    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else if (tick) begin
            prev_q  <= sync_line;
            armed_q <= 1'b1;
        end
    end

    assign fall = tick && armed_q && prev_q && !sync_line;

endmodule

// File: rtl/vga_sync_receiver.sv
// ---------------------------------------------------------------------------
// vga_sync_receiver
//
// Recovers pixel coordinates from a VGA h_sync/v_sync/RGB stream sampled on
// pixel ticks. Free-running horizontal/vertical counters are re-anchored on
// each sync falling edge; a small FSM checks edge spacing and declares lock.
// While locked, every visible tick produces a registered pixel one clk later.
//
// Optional build macro: VGA_RX_STATS_EN adds a wrapping frame counter and a
// saturating sync-error counter. Without it both ports are tied to zero.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   pix_tick     one-cycle pixel strobe; all inputs below are sampled on it
//   h_sync       horizontal sync, active-low
//   v_sync       vertical sync, active-low
//   colors_in    RGB pixel data
//   pix_x/pix_y  coordinates of the captured pixel
//   pix_color    captured RGB
//   pix_valid    one-cycle pulse per captured visible pixel
//   frame_start  pulses with pix_valid for pixel (0,0)
//   sync_err     one-cycle pulse when a locked stream shows bad sync timing
//   locked       high while the FSM is in the locked state
//   frame_count  frames seen (stats build only)
//   err_count    sync errors seen, saturating (stats build only)
// ---------------------------------------------------------------------------
module vga_sync_receiver
    import vga_sync_receiver_pkg::*;
#(
    parameter int unsigned H_TOTAL      = H_TOTAL_STD,
    parameter int unsigned V_TOTAL      = V_TOTAL_STD,
    parameter int unsigned H_VIS        = H_VIS_STD,
    parameter int unsigned V_VIS        = V_VIS_STD,
    parameter int unsigned H_SYNC_START = H_SYNC_START_STD,
    parameter int unsigned V_SYNC_START = V_SYNC_START_STD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_tick,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic [2:0]       colors_in,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [2:0]       pix_color,
    output logic             pix_valid,
    output logic             frame_start,
    output logic             sync_err,
    output logic             locked,
    output logic [15:0]      frame_count,
    output logic [7:0]       err_count
);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_LOAD  = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] V_LOAD  = CNT_W'(V_SYNC_START);
    // Counter value on the tick just before a correctly timed sync edge.
    localparam logic [CNT_W-1:0] H_PRE   = CNT_W'(H_SYNC_START - 1);
    localparam logic [CNT_W-1:0] V_PRE   = CNT_W'(V_SYNC_START - 1);
    localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);

    // -----------------------------------------------------------------------
    // Sync edge detection
    // -----------------------------------------------------------------------
    logic h_fall;
    logic v_fall;

    sync_edge_det u_h_edge (
        .clk       (clk),
        .reset     (reset),
        .tick      (pix_tick),
        .sync_line (h_sync),
        .fall      (h_fall)
    );

    sync_edge_det u_v_edge (
        .clk       (clk),
        .reset     (reset),
        .tick      (pix_tick),
        .sync_line (v_sync),
        .fall      (v_fall)
    );

    // -----------------------------------------------------------------------
    // Position counters. h_cnt_q/v_cnt_q hold the position of the most recent
    // tick; h_cnt_d/v_cnt_d are the position of the tick being sampled now.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_wrap;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        h_wrap  = 1'b0;
        if (pix_tick) begin
            if (h_fall) begin
                h_cnt_d = H_LOAD;
            end else if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                h_wrap  = 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end

            // A v_sync load wins over the line increment on the same tick.
            if (v_fall) begin
                v_cnt_d = V_LOAD;
            end else if (h_wrap) begin
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lock FSM
    // -----------------------------------------------------------------------
    rx_state_e state_q, state_d;
    logic      h_bad;
    logic      v_bad;
    logic      err_d;

    assign h_bad = h_fall && (h_cnt_q != H_PRE);
    assign v_bad = v_fall && (v_cnt_q != V_PRE);

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (h_fall) state_d = StLineChk;
            end
            StLineChk: begin
                if (h_fall) state_d = h_bad ? StSearch : StFrameChk;
            end
            StFrameChk: begin
                // A badly spaced line outranks a v_sync edge on the same tick.
                if (h_bad) begin
                    state_d = StSearch;
                end else if (v_fall) begin
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (h_bad || v_bad) begin
                    state_d = StSearch;
                    err_d   = 1'b1;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    assign locked = (state_q == StLocked);

    // -----------------------------------------------------------------------
    // Pixel capture
    // -----------------------------------------------------------------------
    logic pix_hit;
    logic fs_d;

    assign pix_hit = pix_tick && (state_q == StLocked)
                     && in_active(h_cnt_d, v_cnt_d, H_VIS_C, V_VIS_C);
    assign fs_d    = pix_hit && (h_cnt_d == '0) && (v_cnt_d == '0);

    logic [CNT_W-1:0] pix_x_q, pix_y_q;
    logic [2:0]       pix_color_q;
    logic             pix_valid_q, frame_start_q, sync_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StSearch;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_color_q   <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_valid_q   <= pix_hit;
            frame_start_q <= fs_d;
            sync_err_q    <= err_d;
            if (pix_hit) begin
                pix_x_q     <= h_cnt_d;
                pix_y_q     <= v_cnt_d;
                pix_color_q <= colors_in;
            end
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_color   = pix_color_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;

    // -----------------------------------------------------------------------
    // Optional statistics
    // -----------------------------------------------------------------------
`ifdef VGA_RX_STATS_EN
    logic [15:0] frame_count_q;
    logic [7:0]  err_count_q;

    // Counters step on the same edge that raises frame_start / sync_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            if (fs_d) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (err_d && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
`else
    assign frame_count = '0;
    assign err_count   = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_receiver
//
// Directed bench using a reduced raster (16x10 ticks, 10x6 visible) so whole
// frames fit in a short run. A tick-level generator drives h_sync/v_sync and
// pushes the expected pixel for every visible tick while lock is expected; a
// negedge monitor pops and compares each pix_valid pulse.
// ---------------------------------------------------------------------------
module tb_vga_sync_receiver;

    localparam int HT    = 16;
    localparam int HV    = 10;
    localparam int HS    = 12;
    localparam int VT    = 10;
    localparam int VV    = 6;
    localparam int VS    = 7;
    localparam int FRAME = HT * VT;
    localparam logic [2:0] COLOR = 3'b101;

`ifdef VGA_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_tick = 1'b0;
    logic        h_sync = 1'b1;
    logic        v_sync = 1'b1;
    logic [2:0]  colors_in = COLOR;
    logic [9:0]  pix_x, pix_y;
    logic [2:0]  pix_color;
    logic        pix_valid, frame_start, sync_err, locked;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    vga_sync_receiver #(
        .H_TOTAL      (HT),
        .V_TOTAL      (VT),
        .H_VIS        (HV),
        .V_VIS        (VV),
        .H_SYNC_START (HS),
        .V_SYNC_START (VS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_tick    (pix_tick),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .colors_in   (colors_in),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .sync_err    (sync_err),
        .locked      (locked),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t sb[$];
    pix_t exp_pix;
    pix_t mon_pix;

    int total = 0;
    int bad = 0;
    int gh = 0;
    int gv = 0;
    int line_len = HT;
    int tick_gap = 4;
    bit exp_lock = 1'b0;
    bit storm = 1'b0;
    int pix_cnt = 0;
    int err_seen = 0;
    int exp_frames = 0;
    int exp_err = 0;
    logic [9:0] last_x = '0;
    logic [9:0] last_y = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One generator tick: drive syncs/colour, record the expected pixel, strobe.
    task automatic do_tick();
        h_sync = !(gh >= HS && gh < HS + 2);
        if (storm) v_sync = (gh != 0);
        else       v_sync = !(gv >= VS && gv < VS + 2);
        colors_in = COLOR;
        if (exp_lock && gh < HV && gv < VV) begin
            exp_pix.x = 10'(gh);
            exp_pix.y = 10'(gv);
            exp_pix.c = COLOR;
            sb.push_back(exp_pix);
        end
        pix_tick = 1'b1;
        @(posedge clk); #1;
        pix_tick = 1'b0;
        for (int i = 1; i < tick_gap; i++) begin
            @(posedge clk); #1;
        end
        if (gh >= line_len - 1) begin
            gh = 0;
            line_len = HT;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end else begin
            gh++;
        end
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < 2 * FRAME && !(gh == h && gv == v); i++) do_tick();
    endtask

    task automatic relock(input string tag);
        for (int i = 0; i < 2 * FRAME && !locked; i++) do_tick();
        check(tag, 32'(locked), 32'd1);
        exp_lock = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        int p0;
        run_to(0, 0);
        p0 = pix_cnt;
        repeat (FRAME) do_tick();
        check({tag, "_pixels"}, 32'(pix_cnt - p0), 32'(HV * VV));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_last_x"}, 32'(last_x), 32'(HV - 1));
        check({tag, "_last_y"}, 32'(last_y), 32'(VV - 1));
        check({tag, "_frame_count"}, 32'(frame_count), STATS ? 32'(exp_frames) : 32'd0);
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (sync_err) err_seen++;
        if (pix_valid) begin
            pix_cnt++;
            last_x = pix_x;
            last_y = pix_y;
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_pixel: got x=%0d y=%0d, expected none", pix_x, pix_y);
            end
            if (sb.size() != 0) begin
                mon_pix = sb.pop_front();
                check("pix_x", 32'(pix_x), 32'(mon_pix.x));
                check("pix_y", 32'(pix_y), 32'(mon_pix.y));
                check("pix_color", 32'(pix_color), 32'(mon_pix.c));
                check("frame_start", 32'(frame_start),
                      32'(mon_pix.x == 10'd0 && mon_pix.y == 10'd0));
                if (mon_pix.x == 10'd0 && mon_pix.y == 10'd0) exp_frames++;
            end
        end else begin
            check("frame_start_idle", 32'(frame_start), 32'd0);
        end
    end

    initial begin
        int p0;
        int e0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_pix_x", 32'(pix_x), 32'd0);
        check("rst_pix_y", 32'(pix_y), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;

        // Initial lock: two good lines, then the first v_sync edge
        run_to(0, VS);
        check("not_locked_before_vsync", 32'(locked), 32'd0);
        do_tick();
        check("locked_after_vsync", 32'(locked), 32'd1);
        exp_lock = 1'b1;

        check_frame("frame1");

        // Pause ticks mid-frame; the rest of the frame must resume in step
        p0 = pix_cnt;
        run_to(3, 2);
        e0 = pix_cnt;
        repeat (1000) @(posedge clk);
        #1;
        check("pause_no_pixels", 32'(pix_cnt - e0), 32'd0);
        check("pause_locked", 32'(locked), 32'd1);
        run_to(0, 0);
        check("pause_frame_pixels", 32'(pix_cnt - p0), 32'(HV * VV));
        check("pause_sb_empty", 32'(sb.size()), 32'd0);

        // Shortened line while locked
        run_to(0, VV);
        exp_lock = 1'b0;
        line_len = HT - 1;
        e0 = err_seen;
        run_to(HS + 1, VS);
        exp_err = 1;
        check("short_line_err", 32'(err_seen - e0), 32'd1);
        check("short_line_unlocked", 32'(locked), 32'd0);
        check("short_line_err_count", 32'(err_count), STATS ? 32'(exp_err) : 32'd0);
        relock("relock_after_short");
        check("single_err_pulse", 32'(err_seen - e0), 32'd1);
        check_frame("frame2");

        // One-clk reset mid-frame
        run_to(5, 2);
        check("pre_reset_pix_x", 32'(pix_x), 32'd4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_lock = 1'b0;
        sb.delete();
        exp_frames = 0;
        exp_err = 0;
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_pix_x", 32'(pix_x), 32'd0);
        check("mid_rst_pix_y", 32'(pix_y), 32'd0);
        check("mid_rst_pix_color", 32'(pix_color), 32'd0);
        check("mid_rst_frame_count", 32'(frame_count), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        relock("relock_after_reset");
        check_frame("frame3");

        // Error storm: v_sync falls at every line start; one error per 3 lines
        run_to(0, 0);
        exp_lock = 1'b0;
        e0 = err_seen;
        storm = 1'b1;
        tick_gap = 1;
        repeat (898 * HT) do_tick();
        storm = 1'b0;
        tick_gap = 4;
        exp_err = 255;
        check("storm_err_pulses", 32'(err_seen - e0), 32'd300);
        check("storm_err_count", 32'(err_count), STATS ? 32'(exp_err) : 32'd0);
        relock("relock_after_storm");
        check_frame("frame4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
